// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I subset core with req/ack instruction and data memory ports.
// Each instruction walks FETCH/DECODE/EXEC[/MEM][/WB]; memory wait states simply stretch FETCH and MEM.
module mips_multicycle #(
    parameter logic [31:0] pc_init         = 32'h0,
    parameter logic [31:0] sp_init         = 32'h0,
    parameter logic [31:0] ra_init         = 32'h0,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        instr_ack,
    input  logic [31:0] data_in,
    input  logic        data_ack,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    output logic        data_req,
    output logic        data_rd_wr,
    output logic [31:0] data_addr,
    output logic [31:0] data_out,
    output logic        halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    logic [2:0]         state;
    logic [31:0]        pc;
    logic [31:0]        ir;
    logic [31:0]        regs [32];
    logic signed [31:0] rs_val;
    logic signed [31:0] rt_val;
    logic signed [31:0] imm_sext;
    logic [31:0]        alu_out;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [4:0]  wb_idx;
    logic [31:0] pc_plus4;
    logic [31:0] mem_addr;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [2:0]  trap_state;
    logic        legal;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign target = ir[25:0];

    assign wb_idx        = (opcode == OP_RTYPE) ? rd : rt;
    assign pc_plus4      = pc + 32'd4;
    assign mem_addr      = rs_val + imm_sext;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], target, 2'b00};
    assign trap_state    = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    // Requests are gated by reset so they drop the instant reset asserts.
    assign instr_req  = reset && (state == S_FETCH);
    assign data_req   = reset && (state == S_MEM);
    assign instr_addr = pc;
    assign halted     = (state == S_HALT);

    function automatic logic [31:0] alu_r(input logic [5:0] fn, input logic signed [31:0] a,
                                          input logic signed [31:0] b, input logic [4:0] sh);
        case (fn)
            F_ADDU:  return a + b;
            F_SUBU:  return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_SLT:   return {31'd0, (a < b)};
            F_SLL:   return b << sh;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLL, F_JR: legal = 1'b1;
                    default:                                         legal = 1'b0;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
    end

    // Control: state, PC, register file and memory-port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= pc_init;
            data_rd_wr <= 1'b1;
            data_addr  <= 32'd0;
            data_out   <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            regs[29] <= sp_init;
            regs[31] <= ra_init;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_ack) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state <= trap_state;
                        if (!HALT_ON_ILLEGAL) pc <= pc_plus4;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == F_JR) begin
                                pc    <= rs_val;
                                state <= S_FETCH;
                            end else begin
                                state <= S_WB;
                            end
                        end
                        OP_ADDIU: state <= S_WB;
                        OP_LW, OP_SW: begin
                            if (mem_addr[1:0] != 2'b00) begin
                                state <= trap_state;
                                if (!HALT_ON_ILLEGAL) pc <= pc_plus4;
                            end else begin
                                data_addr  <= mem_addr;
                                data_rd_wr <= (opcode == OP_LW);
                                data_out   <= rt_val;
                                state      <= S_MEM;
                            end
                        end
                        OP_BEQ: begin
                            pc    <= (rs_val == rt_val) ? branch_target : pc_plus4;
                            state <= S_FETCH;
                        end
                        OP_BNE: begin
                            pc    <= (rs_val != rt_val) ? branch_target : pc_plus4;
                            state <= S_FETCH;
                        end
                        OP_J: begin
                            pc    <= jump_target;
                            state <= S_FETCH;
                        end
                        OP_JAL: begin
                            regs[31] <= pc_plus4;
                            pc       <= jump_target;
                            state    <= S_FETCH;
                        end
                        default: begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (data_ack) begin
                        if (data_rd_wr) begin
                            state <= S_WB;
                        end else begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) regs[wb_idx] <= alu_out;
                    pc    <= pc_plus4;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Datapath: instruction register, operand latches and result register
    always_ff @(posedge clk) begin
        case (state)
            S_FETCH: begin
                if (instr_ack && instr_req) ir <= instr_in;
            end
            S_DECODE: begin
                rs_val   <= regs[rs];
                rt_val   <= regs[rt];
                imm_sext <= {{16{imm[15]}}, imm};
            end
            S_EXEC: begin
                alu_out <= (opcode == OP_RTYPE) ? alu_r(funct, rs_val, rt_val, shamt) : mem_addr;
            end
            S_MEM: begin
                if (data_ack && data_req) alu_out <= data_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: one instance halts on illegal input, the other treats it as a NOP.
module tb_mips_multicycle;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        a_reset = 1'b1, a_instr_ack = 1'b0, a_data_ack = 1'b0;
    logic [31:0] a_instr_in = 32'd0, a_data_in = 32'd0;
    logic        a_instr_req, a_data_req, a_data_rd_wr, a_halted;
    logic [31:0] a_instr_addr, a_data_addr, a_data_out;

    logic        b_reset = 1'b1, b_instr_ack = 1'b0, b_data_ack = 1'b0;
    logic [31:0] b_instr_in = 32'd0, b_data_in = 32'd0;
    logic        b_instr_req, b_data_req, b_data_rd_wr, b_halted;
    logic [31:0] b_instr_addr, b_data_addr, b_data_out;

    mips_multicycle #(.pc_init(32'h400), .sp_init(32'h7FFC), .ra_init(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(a_reset), .instr_in(a_instr_in), .instr_ack(a_instr_ack),
        .data_in(a_data_in), .data_ack(a_data_ack), .instr_req(a_instr_req), .instr_addr(a_instr_addr),
        .data_req(a_data_req), .data_rd_wr(a_data_rd_wr), .data_addr(a_data_addr),
        .data_out(a_data_out), .halted(a_halted));

    mips_multicycle #(.pc_init(32'h0), .sp_init(32'h0), .ra_init(32'h0), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(b_reset), .instr_in(b_instr_in), .instr_ack(b_instr_ack),
        .data_in(b_data_in), .data_ack(b_data_ack), .instr_req(b_instr_req), .instr_addr(b_instr_addr),
        .data_req(b_data_req), .data_rd_wr(b_data_rd_wr), .data_addr(b_data_addr),
        .data_out(b_data_out), .halted(b_halted));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ireq(input bit s);
        return s ? b_instr_req : a_instr_req;
    endfunction
    function automatic logic [31:0] iaddr(input bit s);
        return s ? b_instr_addr : a_instr_addr;
    endfunction
    function automatic logic dreq(input bit s);
        return s ? b_data_req : a_data_req;
    endfunction
    function automatic logic [64:0] dport(input bit s);
        return s ? {b_data_addr, b_data_rd_wr, b_data_out} : {a_data_addr, a_data_rd_wr, a_data_out};
    endfunction

    // Waits for a fetch request, holds ack off for 'waits' cycles, then completes it.
    task automatic fetch(input bit s, input logic [31:0] instr, input int waits,
                         output logic [31:0] addr, output int t, output bit stable);
        int n = 0;
        stable = 1'b1;
        while (!ireq(s) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ireq(s)) begin
            addr = 'x;
            t = -1000;
            stable = 1'b0;
            return;
        end
        addr = iaddr(s);
        t = cyc;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            if (!ireq(s) || iaddr(s) !== addr) stable = 1'b0;
        end
        if (s) begin b_instr_in = instr; b_instr_ack = 1'b1; end
        else   begin a_instr_in = instr; a_instr_ack = 1'b1; end
        @(negedge clk);
        if (s) begin b_instr_in = 32'd0; b_instr_ack = 1'b0; end
        else   begin a_instr_in = 32'd0; a_instr_ack = 1'b0; end
    endtask

    // Waits for a data request, captures {addr, rd_wr, wdata}, completes it after 'waits' cycles.
    task automatic mem(input bit s, input logic [31:0] rdata, input int waits,
                       output logic [64:0] port, output int t, output bit stable);
        int n = 0;
        stable = 1'b1;
        while (!dreq(s) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dreq(s)) begin
            port = 'x;
            t = -1000;
            stable = 1'b0;
            return;
        end
        port = dport(s);
        t = cyc;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            if (!dreq(s) || dport(s) !== port || ireq(s)) stable = 1'b0;
        end
        if (s) begin b_data_in = rdata; b_data_ack = 1'b1; end
        else   begin a_data_in = rdata; a_data_ack = 1'b1; end
        @(negedge clk);
        if (s) begin b_data_in = 32'd0; b_data_ack = 1'b0; end
        else   begin a_data_in = 32'd0; a_data_ack = 1'b0; end
    endtask

    task automatic test_reset();
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_instr_req, a_data_req, a_data_rd_wr, a_halted} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0010", {a_instr_req, a_data_req, a_data_rd_wr, a_halted});
        end
        checks++;
        if ({a_instr_addr, a_data_addr, a_data_out} !== {32'h400, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_addr: got %h %h %h expected 400 0 0", a_instr_addr, a_data_addr, a_data_out);
        end
        checks++;
        if (b_instr_addr !== 32'h0 || b_instr_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: got addr %h req %b expected 0 0", b_instr_addr, b_instr_req);
        end
        a_reset = 1'b1;
        b_reset = 1'b1;
        #1;
        checks++;
        if (a_instr_req !== 1'b1 || a_instr_addr !== 32'h400) begin
            failures++;
            $display("FAIL first_fetch: got req %b addr %h expected 1 400", a_instr_req, a_instr_addr);
        end
    endtask

    task automatic test_sw_sp();
        logic [31:0] addr;
        logic [64:0] port;
        int t;
        bit st;
        fetch(0, 32'hAC1D0000, 0, addr, t, st);
        checks++;
        if (addr !== 32'h400) begin
            failures++;
            $display("FAIL sw_sp_fetch: got %h expected 400", addr);
        end
        mem(0, 32'd0, 0, port, t, st);
        checks++;
        if (port !== {32'h0, 1'b0, 32'h7FFC}) begin
            failures++;
            $display("FAIL sw_sp_store: got %h expected %h", port, {32'h0, 1'b0, 32'h7FFC});
        end
    endtask

    task automatic test_addiu_seq();
        logic [31:0] prog [4];
        logic [31:0] addr;
        logic [64:0] port;
        int t, t0, tm;
        bit st;
        prog = '{32'h24010005, 32'h2402FFFD, 32'h00221821, 32'hAC030008};
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            fetch(0, prog[i], 0, addr, t, st);
            if (i == 0) t0 = t;
            checks++;
            if (addr !== 32'(32'h404 + 4 * i)) begin
                failures++;
                $display("FAIL seq_fetch%0d: got %h expected %h", i, addr, 32'(32'h404 + 4 * i));
            end
        end
        mem(0, 32'd0, 0, port, tm, st);
        checks++;
        if (port !== {32'h8, 1'b0, 32'h2}) begin
            failures++;
            $display("FAIL seq_store: got %h expected %h", port, {32'h8, 1'b0, 32'h2});
        end
        checks++;
        if (tm - t0 !== 15) begin
            failures++;
            $display("FAIL seq_timing: got %0d expected 15", tm - t0);
        end
    endtask

    task automatic test_lw_wait();
        logic [31:0] addr;
        logic [64:0] port;
        int t0, t1, tm;
        bit st;
        fetch(0, 32'h8C05000C, 3, addr, t0, st);
        checks++;
        if (addr !== 32'h414 || st !== 1'b1) begin
            failures++;
            $display("FAIL lw_fetch: got %h stable %b expected 414 1", addr, st);
        end
        mem(0, 32'hDEADBEEF, 2, port, tm, st);
        checks++;
        if (port[64:32] !== {32'hC, 1'b1} || st !== 1'b1) begin
            failures++;
            $display("FAIL lw_access: got %h stable %b expected %h 1", port[64:32], st, {32'hC, 1'b1});
        end
        fetch(0, 32'hAC050010, 0, addr, t1, st);
        checks++;
        if (addr !== 32'h418 || t1 - t0 !== 10) begin
            failures++;
            $display("FAIL lw_time: got addr %h cycles %0d expected 418 10", addr, t1 - t0);
        end
        mem(0, 32'd0, 0, port, tm, st);
        checks++;
        if (port !== {32'h10, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lw_value: got %h expected %h", port, {32'h10, 1'b0, 32'hDEADBEEF});
        end
    endtask

    task automatic test_branch();
        logic [31:0] prog [6];
        logic [31:0] exp_addr [6];
        logic [31:0] addr;
        logic [64:0] port;
        int t, t0;
        bit st;
        prog     = '{32'h1000FFFF, 32'h14000005, 32'h08000040, 32'h0C000080, 32'hAC1F0014, 32'h03E00008};
        exp_addr = '{32'h41C, 32'h41C, 32'h420, 32'h100, 32'h200, 32'h204};
        t0 = 0;
        for (int i = 0; i < 6; i++) begin
            fetch(0, prog[i], 0, addr, t, st);
            checks++;
            if (addr !== exp_addr[i]) begin
                failures++;
                $display("FAIL branch_fetch%0d: got %h expected %h", i, addr, exp_addr[i]);
            end
            if (i == 0) t0 = t;
            if (i == 1) begin
                checks++;
                if (t - t0 !== 3) begin
                    failures++;
                    $display("FAIL branch_time: got %0d expected 3", t - t0);
                end
            end
            if (i == 4) begin
                mem(0, 32'd0, 0, port, t, st);
                checks++;
                if (port !== {32'h14, 1'b0, 32'h104}) begin
                    failures++;
                    $display("FAIL jal_link: got %h expected %h", port, {32'h14, 1'b0, 32'h104});
                end
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] op [5];
        logic [31:0] sw [5];
        logic [31:0] res [5];
        logic [31:0] addr;
        logic [64:0] port;
        int t;
        bit st;
        op  = '{32'h00223823, 32'h0041302A, 32'h00014100, 32'h00224824, 32'h00225025};
        sw  = '{32'hAC07001C, 32'hAC060018, 32'hAC080020, 32'hAC090024, 32'hAC0A0028};
        res = '{32'h8, 32'h1, 32'h50, 32'h5, 32'hFFFFFFFD};
        for (int i = 0; i < 5; i++) begin
            fetch(0, op[i], 0, addr, t, st);
            checks++;
            if (addr !== 32'(32'h104 + 8 * i)) begin
                failures++;
                $display("FAIL alu_fetch%0d: got %h expected %h", i, addr, 32'(32'h104 + 8 * i));
            end
            fetch(0, sw[i], 0, addr, t, st);
            mem(0, 32'd0, 0, port, t, st);
            checks++;
            if (port[31:0] !== res[i]) begin
                failures++;
                $display("FAIL alu_result%0d: got %h expected %h", i, port[31:0], res[i]);
            end
        end
    endtask

    task automatic test_illegal_halt();
        logic [31:0] addr;
        int t;
        bit st, any_req;
        fetch(0, 32'hFC000000, 0, addr, t, st);
        checks++;
        if (addr !== 32'h12C) begin
            failures++;
            $display("FAIL illegal_fetch: got %h expected 12C", addr);
        end
        any_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_instr_req || a_data_req) any_req = 1'b1;
        end
        checks++;
        if (a_halted !== 1'b1 || any_req !== 1'b0) begin
            failures++;
            $display("FAIL illegal_halt: got halted %b req %b expected 1 0", a_halted, any_req);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] addr;
        int t, n;
        bit st, ok, any_req;
        a_reset = 1'b0;
        @(negedge clk);
        a_reset = 1'b1;
        #1;
        fetch(0, 32'hAC1D0000, 0, addr, t, st);
        checks++;
        if (addr !== 32'h400 || a_halted !== 1'b0) begin
            failures++;
            $display("FAIL restart_fetch: got %h halted %b expected 400 0", addr, a_halted);
        end
        n = 0;
        while (!a_data_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2;
        a_reset = 1'b0;
        #1;
        checks++;
        if (a_data_req !== 1'b0 || a_instr_req !== 1'b0 || n >= 10) begin
            failures++;
            $display("FAIL mid_reset_drop: got data_req %b instr_req %b waited %0d expected 0 0 <10",
                     a_data_req, a_instr_req, n);
        end
        @(negedge clk);
        a_reset = 1'b1;
        a_data_ack = 1'b1;
        a_data_in = 32'h12345678;
        #1;
        checks++;
        if (a_instr_req !== 1'b1 || a_instr_addr !== 32'h400) begin
            failures++;
            $display("FAIL mid_reset_restart: got req %b addr %h expected 1 400", a_instr_req, a_instr_addr);
        end
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!a_instr_req || a_instr_addr !== 32'h400 || a_data_req) ok = 1'b0;
        end
        a_data_ack = 1'b0;
        a_data_in = 32'd0;
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL late_ack_ignored: got %b expected 1", ok);
        end
        fetch(0, 32'h8C010002, 0, addr, t, st);
        any_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (a_instr_req || a_data_req) any_req = 1'b1;
        end
        checks++;
        if (addr !== 32'h400 || a_halted !== 1'b1 || any_req !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_halt: got addr %h halted %b req %b expected 400 1 0", addr, a_halted, any_req);
        end
    endtask

    task automatic test_illegal_nop();
        logic [31:0] addr;
        logic [64:0] port;
        int t0, t1, t2;
        bit st;
        fetch(1, 32'hFC000000, 0, addr, t0, st);
        checks++;
        if (addr !== 32'h0) begin
            failures++;
            $display("FAIL nop_fetch0: got %h expected 0", addr);
        end
        fetch(1, 32'h8C010002, 0, addr, t1, st);
        checks++;
        if (addr !== 32'h4 || t1 - t0 !== 2 || b_halted !== 1'b0) begin
            failures++;
            $display("FAIL nop_illegal_skip: got addr %h cycles %0d halted %b expected 4 2 0", addr, t1 - t0, b_halted);
        end
        fetch(1, 32'hAC010000, 0, addr, t2, st);
        checks++;
        if (addr !== 32'h8 || t2 - t1 !== 3) begin
            failures++;
            $display("FAIL nop_misaligned_skip: got addr %h cycles %0d expected 8 3", addr, t2 - t1);
        end
        mem(1, 32'd0, 0, port, t2, st);
        checks++;
        if (port !== {32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL nop_reg_untouched: got %h expected %h", port, {32'h0, 1'b0, 32'h0});
        end
    endtask

    initial begin
        test_reset();
        test_sw_sp();
        test_addiu_seq();
        test_lw_wait();
        test_branch();
        test_alu();
        test_illegal_halt();
        test_reset_mid_access();
        test_illegal_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
Multi-cycle MIPS-I subset core. It is the next generation of the non-pipelined mips core. Instruction and data memory are accessed through req/ack handshakes, so the core runs with memories that take any number of wait states. It adds illegal-instruction detection with a configurable halt mode. It sits between the instruction memory and the data memory, in the same position as the existing core.

Parameters:
pc_init, 32'h0, program counter value after reset
sp_init, 32'h0, value of $29 after reset
ra_init, 32'h0, value of $31 after reset
HALT_ON_ILLEGAL, 1, 1 = unsupported opcode or misaligned access enters HALT; 0 = it executes as a NOP

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_in  in  32  instruction word from instruction memory, valid while instr_ack=1
instr_ack  in  1  instruction memory completes the fetch this cycle
data_in  in  32  load data, valid while data_ack=1
data_ack  in  1  data memory completes the access this cycle
instr_req  out  1  fetch request
instr_addr  out  32  fetch address (= PC)
data_req  out  1  data access request
data_rd_wr  out  1  1 = read, 0 = write
data_addr  out  32  data word address
data_out  out  32  store data
halted  out  1  core is in HALT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, PC=pc_init, $29=sp_init, $31=ra_init, all other registers 0.
  - instr_req=0, data_req=0, data_rd_wr=1, instr_addr=pc_init, data_addr=0, data_out=0, halted=0.
- Reset asserted mid-access: requests drop immediately; a pending ack is ignored.
- Register $0 reads 0; writes to it are discarded.
- States and transitions:
  - FETCH: instr_req=1, instr_addr=PC. On instr_ack: IR<=instr_in, go to DECODE. Otherwise stay, holding all outputs stable.
  - DECODE (1 cycle): read rs/rt, sign-extend and zero-extend imm. Illegal opcode/funct -> HALT (HALT_ON_ILLEGAL=1) or PC+=4, FETCH (=0).
  - EXEC (1 cycle): ALU operation or address/branch computation.
    - BEQ/BNE/J/JR update PC, then FETCH.
    - JAL: $31<=PC+4, PC<=target, FETCH.
    - LW/SW with addr[1:0]!=0 is treated as illegal (same rule as DECODE).
    - LW/SW -> MEM; R-type/ADDIU -> WB.
  - MEM: data_req=1 with data_addr/data_rd_wr/data_out held stable until data_ack.
    - On ack: LW latches data_in -> WB; SW -> PC+=4, FETCH.
  - WB (1 cycle): write rd (R-type) or rt (ADDIU/LW); PC+=4; FETCH.
  - HALT: all requests 0, halted=1. Only reset exits.
- Supported instructions: ADDU, SUBU, AND, OR, SLT, SLL, JR, ADDIU, LW, SW, BEQ, BNE, J, JAL. Any other opcode/funct is illegal.
- Arithmetic rules:
  - 32-bit wrap-around, no overflow trap.
  - SLT is signed.
  - Branch target = PC+4 + (sext(imm)<<2).
  - J/JAL target = {PC+4[31:28], imm26, 2'b00}.
  - No delay slot.
- Cycle counts with zero wait (ack in the same cycle as req):
  - R-type/ADDIU = 4, LW = 5, SW = 4, branch/jump = 3.
  - Each wait cycle adds 1.
- An ack arriving while the matching req=0 is ignored.
- instr_req and data_req are never both 1 in the same cycle.

Test Plan:
- Reset with pc_init=32'h400, sp_init=32'h7FFC -> instr_addr=32'h400, instr_req=1 in the first cycle after reset deasserts; SW $29,0($0) stores data_out=32'h7FFC at data_addr=0.
- ADDIU $1,$0,5; ADDIU $2,$0,-3; ADDU $3,$1,$2; SW $3,8($0) with zero wait -> data_addr=8, data_out=2, data_rd_wr=0; the SW data_req rises 15 cycles after the first instr_req.
- Instruction ack delayed 3 cycles and data ack delayed 2 cycles on LW -> instr_addr/data_addr stay stable while waiting; the loaded value is written to rt; total LW time = 10 cycles.
- BEQ taken with imm=-1 -> next instr_addr = PC; BNE not taken -> PC+4; JAL from 32'h100 -> $31=32'h104, and a following JR $31 returns to 32'h104.
- Illegal opcode 6'h3F: with HALT_ON_ILLEGAL=1, halted=1 and no further requests; with HALT_ON_ILLEGAL=0, the next fetch is at PC+4. LW at address 32'h2 behaves the same way.
- reset driven 0 while data_req=1 and ack has not arrived -> data_req=0 immediately; after release, fetch restarts at pc_init and a late data_ack is ignored.
